ball_physics: RTL and testbench
===============================

BALL_PHYSICS -- requirements
Module: ball_physics

Interface
REQ-001 Parameter COORD_W, 10, position/size width in bits.
REQ-002 Parameter VEL_W, 8, signed velocity width in bits.
REQ-003 Parameters BALL_S=12, X_MIN=0, X_MAX=639, Y_MIN=0, Y_FLOOR=440, GOAL_TOP=340, X_CENTER=320, SPAWN_Y=100 (pixels).
REQ-004 Parameters GRAVITY=1 (px/frame per tick), GRAV_DIV=2 (frames per gravity tick), VMAX=15 (speed clamp), HOLD_FRAMES=60 (goal freeze length).
REQ-005 frame_clk  in  1  sole clock, one rising edge per video frame.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 kick_valid  in  1  apply kick velocity this frame.
REQ-008 kick_vx, kick_vy  in  VEL_W each  signed replacement velocity.
REQ-009 BallX, BallY  out  COORD_W each  ball centre, registered.
REQ-010 BallS  out  COORD_W  constant BALL_S.
REQ-011 BallVX, BallVY  out  VEL_W each  signed current velocity, registered.
REQ-012 goal_left, goal_right  out  1 each  one-cycle goal pulses.
REQ-013 in_play  out  1  high when state is PLAY.

Function
REQ-014 The block SHALL update state once per frame_clk edge; all outputs SHALL be registered.
REQ-015 FSM states SHALL be PLAY, GOAL_HOLD, RESPAWN; the Reset state is PLAY.
REQ-016 The gravity counter SHALL count 0..GRAV_DIV-1 in PLAY only; the gravity tick is asserted when the counter equals GRAV_DIV-1.
REQ-017 In PLAY with kick_valid: vx_n=kick_vx, vy_n=kick_vy, and no gravity is applied that frame.
REQ-018 In PLAY without kick_valid: vx_n=BallVX, and vy_n=BallVY+GRAVITY on a tick, else BallVY.
REQ-019 vx_n and vy_n SHALL be clamped to [-VMAX,+VMAX] before use.
REQ-020 Next position SHALL be pos+vel_n, computed in signed COORD_W+2 bits so that no underflow wraps.
REQ-021 Floor case, Y_next+S>=Y_FLOOR: BallY=Y_FLOOR-S and BallVY=-(vy_n>>>1) (arithmetic shift); if |vy_n|<=1, BallVY=0.
REQ-022 Floor resting, BallY+S==Y_FLOOR and vy_n==0: vx SHALL decay 1 toward 0 each frame (friction).
REQ-023 Ceiling case, Y_next-S<=Y_MIN: BallY=Y_MIN+S and BallVY=-vy_n.
REQ-024 Left wall case, X_next-S<=X_MIN: if clamped BallY>=GOAL_TOP, enter GOAL_HOLD and pulse goal_left; otherwise BallX=X_MIN+S and BallVX=-vx_n.
REQ-025 The right wall is symmetric at X_MAX, using X_next+S>=X_MAX and pulsing goal_right.
REQ-026 X and Y boundary handling SHALL be independent; a goal uses the Y value already clamped that frame.
REQ-027 Goal pulses SHALL be high exactly one cycle, the first cycle of GOAL_HOLD; the goal side's BallX SHALL be clamped to the wall.
REQ-028 In GOAL_HOLD, position SHALL be frozen, velocity zero, and kicks ignored for HOLD_FRAMES cycles (down-counter); then the FSM moves to RESPAWN.
REQ-029 RESPAWN (one cycle): BallX=X_CENTER, BallY=SPAWN_Y, velocity 0, gravity counter 0; the next state is PLAY.

Reset
REQ-030 On Reset: BallX=X_CENTER, BallY=SPAWN_Y, BallVX=BallVY=0, gravity counter 0, hold counter 0, goals low, in_play=1, state PLAY.
REQ-031 Reset SHALL override every state, including mid-GOAL_HOLD, on the same edge.

Verification
REQ-032 Reset, then release with no kicks for 4 frames -> BallY=104, BallVY=2, BallX=320.
REQ-033 Hold kick vx=0, vy=+10 -> on the frame Y_next+12>=440: BallY=428, BallVY=-5; kick vy=+100 -> BallVY clamped to 15.
REQ-034 At Y=100, hold kick vx=-8, vy=0 -> BallY stays 100; at the wall BallX=12, BallVX=+8, no goal pulse.
REQ-035 With the ball on the floor (Y=428), hold kick vx=-8 -> goal_left high exactly 1 cycle, in_play=0 for 61 cycles, then BallX=320, BallY=100, velocity 0.
REQ-036 Assert Reset during GOAL_HOLD -> next edge shows reset values, in_play=1, goals low.

Source files
------------

// File: rtl/ball_physics.sv
// rtl/ball_physics.sv - per-frame ball kinematics with gravity, bounces and goal detection
module ball_physics #(
  parameter int COORD_W     = 10,
  parameter int VEL_W       = 8,
  parameter int BALL_S      = 12,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int Y_MIN       = 0,
  parameter int Y_FLOOR     = 440,
  parameter int GOAL_TOP    = 340,
  parameter int X_CENTER    = 320,
  parameter int SPAWN_Y     = 100,
  parameter int GRAVITY     = 1,
  parameter int GRAV_DIV    = 2,
  parameter int VMAX        = 15,
  parameter int HOLD_FRAMES = 60
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               kick_valid,
  input  logic [VEL_W-1:0]   kick_vx,
  input  logic [VEL_W-1:0]   kick_vy,
  output logic [COORD_W-1:0] BallX,
  output logic [COORD_W-1:0] BallY,
  output logic [COORD_W-1:0] BallS,
  output logic [VEL_W-1:0]   BallVX,
  output logic [VEL_W-1:0]   BallVY,
  output logic               goal_left,
  output logic               goal_right,
  output logic               in_play
);
  // Positions are resolved in two extra signed bits so a step past 0 stays negative.
  localparam int PW = COORD_W + 2;
  localparam int VW = VEL_W + 1;
  localparam int GW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic signed [PW-1:0]    P_S     = PW'(BALL_S);
  localparam logic signed [PW-1:0]    P_XMIN  = PW'(X_MIN);
  localparam logic signed [PW-1:0]    P_XMAX  = PW'(X_MAX);
  localparam logic signed [PW-1:0]    P_YMIN  = PW'(Y_MIN);
  localparam logic signed [PW-1:0]    P_FLOOR = PW'(Y_FLOOR);
  localparam logic signed [VW-1:0]    V_MAX   = VW'(VMAX);
  localparam logic signed [VW-1:0]    V_NMAX  = VW'(-VMAX);
  localparam logic signed [VW-1:0]    V_GRAV  = VW'(GRAVITY);
  localparam logic signed [VW-1:0]    V_NOG   = VW'(0);
  localparam logic signed [VEL_W-1:0] V_ZERO  = VEL_W'(0);
  localparam logic signed [VEL_W-1:0] V_ONE   = VEL_W'(1);
  localparam logic signed [VEL_W-1:0] V_NONE  = VEL_W'(-1);
  localparam logic [COORD_W-1:0]      C_REST  = COORD_W'(Y_FLOOR - BALL_S);
  localparam logic [COORD_W-1:0]      C_CEIL  = COORD_W'(Y_MIN + BALL_S);
  localparam logic [COORD_W-1:0]      C_LWALL = COORD_W'(X_MIN + BALL_S);
  localparam logic [COORD_W-1:0]      C_RWALL = COORD_W'(X_MAX - BALL_S);
  localparam logic [COORD_W-1:0]      C_GTOP  = COORD_W'(GOAL_TOP);
  localparam logic [COORD_W-1:0]      C_XC    = COORD_W'(X_CENTER);
  localparam logic [COORD_W-1:0]      C_SY    = COORD_W'(SPAWN_Y);
  localparam logic [GW-1:0]           G_LAST  = GW'(GRAV_DIV - 1);
  localparam logic [GW-1:0]           G_ONE   = GW'(1);
  localparam logic [HW-1:0]           H_LOAD  = HW'(HOLD_FRAMES);
  localparam logic [HW-1:0]           H_ONE   = HW'(1);

  typedef enum logic [1:0] {PLAY, GOAL_HOLD, RESPAWN} state_t;

  state_t                    state_q, state_d;
  logic [GW-1:0]             gcnt_q, gcnt_d;
  logic [HW-1:0]             hcnt_q, hcnt_d;
  logic [COORD_W-1:0]        x_d, y_d;
  logic [VEL_W-1:0]          vx_d, vy_d;
  logic                      gl_d, gr_d;

  logic                      grav_tick, resting, hit_l, hit_r, goal_l, goal_r;
  logic signed [VW-1:0]      g_add, vx_raw, vy_raw;
  logic signed [VEL_W-1:0]   vx_n, vy_n, vx_st, vy_st;
  logic signed [PW-1:0]      x_nx, y_nx;
  logic [COORD_W-1:0]        x_cl, y_cl;

  assign BallS = COORD_W'(BALL_S);

  // Candidate PLAY-frame motion: pick velocity, clamp, move, then resolve Y before X
  always_comb begin
    grav_tick = (gcnt_q == G_LAST);
    g_add     = grav_tick ? V_GRAV : V_NOG;
    if (kick_valid) begin
      vx_raw = VW'($signed(kick_vx));
      vy_raw = VW'($signed(kick_vy));
    end else begin
      vx_raw = VW'($signed(BallVX));
      vy_raw = VW'($signed(BallVY)) + g_add;
    end
    vx_n = VEL_W'((vx_raw > V_MAX) ? V_MAX : ((vx_raw < V_NMAX) ? V_NMAX : vx_raw));
    vy_n = VEL_W'((vy_raw > V_MAX) ? V_MAX : ((vy_raw < V_NMAX) ? V_NMAX : vy_raw));
    x_nx = PW'($signed({1'b0, BallX})) + PW'(vx_n);
    y_nx = PW'($signed({1'b0, BallY})) + PW'(vy_n);

    y_cl  = y_nx[COORD_W-1:0];
    vy_st = vy_n;
    if (y_nx + P_S >= P_FLOOR) begin
      y_cl  = C_REST;
      vy_st = (vy_n >= V_NONE && vy_n <= V_ONE) ? V_ZERO : -(vy_n >>> 1);
    end else if (y_nx - P_S <= P_YMIN) begin
      y_cl  = C_CEIL;
      vy_st = -vy_n;
    end

    // A ball lying on the floor with no vertical motion loses one unit of vx per frame
    resting = !kick_valid && (BallY == C_REST) && (vy_n == V_ZERO);
    vx_st   = vx_n;
    if (resting) begin
      if (vx_n > V_ZERO)      vx_st = vx_n - V_ONE;
      else if (vx_n < V_ZERO) vx_st = vx_n + V_ONE;
    end

    hit_l  = (x_nx - P_S <= P_XMIN);
    hit_r  = !hit_l && (x_nx + P_S >= P_XMAX);
    goal_l = hit_l && (y_cl >= C_GTOP);
    goal_r = hit_r && (y_cl >= C_GTOP);
    x_cl   = x_nx[COORD_W-1:0];
    if (hit_l) begin
      x_cl  = C_LWALL;
      vx_st = -vx_n;
    end else if (hit_r) begin
      x_cl  = C_RWALL;
      vx_st = -vx_n;
    end
  end

  // State register
  always_ff @(posedge frame_clk) begin
    if (Reset) state_q <= PLAY;
    else       state_q <= state_d;
  end

  // Next-state: goal freezes play, hold counts down, respawn lasts one frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      PLAY:      if (goal_l || goal_r) state_d = GOAL_HOLD;
      GOAL_HOLD: if (hcnt_q <= H_ONE)  state_d = RESPAWN;
      RESPAWN:   state_d = PLAY;
      default:   state_d = PLAY;
    endcase
  end

  // Datapath next values per state
  always_comb begin
    x_d    = BallX;
    y_d    = BallY;
    vx_d   = BallVX;
    vy_d   = BallVY;
    gcnt_d = gcnt_q;
    hcnt_d = hcnt_q;
    gl_d   = 1'b0;
    gr_d   = 1'b0;
    case (state_q)
      PLAY: begin
        x_d    = x_cl;
        y_d    = y_cl;
        vx_d   = vx_st;
        vy_d   = vy_st;
        gcnt_d = grav_tick ? '0 : gcnt_q + G_ONE;
        if (goal_l || goal_r) begin
          vx_d   = '0;
          vy_d   = '0;
          hcnt_d = H_LOAD;
          gl_d   = goal_l;
          gr_d   = goal_r;
        end
      end
      GOAL_HOLD: begin
        hcnt_d = (hcnt_q != '0) ? hcnt_q - H_ONE : '0;
        if (state_d == RESPAWN) begin
          x_d    = C_XC;
          y_d    = C_SY;
          vx_d   = '0;
          vy_d   = '0;
          gcnt_d = '0;
        end
      end
      RESPAWN: begin
        x_d    = C_XC;
        y_d    = C_SY;
        vx_d   = '0;
        vy_d   = '0;
        gcnt_d = '0;
      end
      default: ;
    endcase
  end

  // Registered outputs and counters
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      BallX      <= C_XC;
      BallY      <= C_SY;
      BallVX     <= '0;
      BallVY     <= '0;
      gcnt_q     <= '0;
      hcnt_q     <= '0;
      goal_left  <= 1'b0;
      goal_right <= 1'b0;
      in_play    <= 1'b1;
    end else begin
      BallX      <= x_d;
      BallY      <= y_d;
      BallVX     <= vx_d;
      BallVY     <= vy_d;
      gcnt_q     <= gcnt_d;
      hcnt_q     <= hcnt_d;
      goal_left  <= gl_d;
      goal_right <= gr_d;
      in_play    <= (state_d == PLAY);
    end
  end

endmodule

// File: tb/tb_ball_physics.sv
// tb/tb_ball_physics.sv - scoreboard bench for ball_physics
module tb_ball_physics;
  localparam int S = 12, XMIN = 0, XMAX = 639, YMIN = 0, FLOOR = 440, GTOP = 340;
  localparam int XC = 320, SY = 100, GDIV = 2, VMAX = 15, HOLD = 60;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       kick_valid = 1'b0;
  logic [7:0] kick_vx = '0;
  logic [7:0] kick_vy = '0;
  logic [9:0] BallX, BallY, BallS;
  logic [7:0] BallVX, BallVY;
  logic       goal_left, goal_right, in_play;

  ball_physics dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .kick_valid(kick_valid),
    .kick_vx   (kick_vx),
    .kick_vy   (kick_vy),
    .BallX     (BallX),
    .BallY     (BallY),
    .BallS     (BallS),
    .BallVX    (BallVX),
    .BallVY    (BallVY),
    .goal_left (goal_left),
    .goal_right(goal_right),
    .in_play   (in_play)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int x; int y; int vx; int vy; int gl; int gr; int ip;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   mx, my, mvx, mvy, mg, mh, ms, m_gl, m_gr;
  int   gl_cnt = 0, gr_cnt = 0, ip_low = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampv(input int v);
    return (v > VMAX) ? VMAX : ((v < -VMAX) ? -VMAX : v);
  endfunction

  task automatic model_reset();
    mx = XC; my = SY; mvx = 0; mvy = 0; mg = 0; mh = 0; ms = 0; m_gl = 0; m_gr = 0;
  endtask

  // Reference behaviour, ms: 0 = play, 1 = goal hold, 2 = respawn
  task automatic model_step(input bit kv, input int kx, input int ky);
    int  vxn, vyn, xn, yn, vxs, vys;
    bit  tick;
    m_gl = 0; m_gr = 0;
    if (ms == 0) begin
      tick = (mg == GDIV - 1);
      mg   = tick ? 0 : mg + 1;
      if (kv) begin vxn = kx; vyn = ky; end
      else begin vxn = mvx; vyn = mvy + (tick ? 1 : 0); end
      vxn = clampv(vxn);
      vyn = clampv(vyn);
      xn = mx + vxn; yn = my + vyn; vxs = vxn; vys = vyn;
      if (yn + S >= FLOOR) begin
        yn = FLOOR - S;
        vys = (vyn >= -1 && vyn <= 1) ? 0 : -(vyn >>> 1);
      end else if (yn - S <= YMIN) begin
        yn = YMIN + S; vys = -vyn;
      end
      if (!kv && my == FLOOR - S && vyn == 0)
        vxs = (vxn > 0) ? vxn - 1 : ((vxn < 0) ? vxn + 1 : 0);
      if (xn - S <= XMIN) begin
        xn = XMIN + S; vxs = -vxn;
        if (yn >= GTOP) m_gl = 1;
      end else if (xn + S >= XMAX) begin
        xn = XMAX - S; vxs = -vxn;
        if (yn >= GTOP) m_gr = 1;
      end
      if (m_gl || m_gr) begin
        ms = 1; mh = HOLD; vxs = 0; vys = 0;
      end
      mx = xn; my = yn; mvx = vxs; mvy = vys;
    end else if (ms == 1) begin
      if (mh <= 1) begin
        ms = 2; mx = XC; my = SY; mvx = 0; mvy = 0; mg = 0;
      end
      if (mh > 0) mh--;
    end else begin
      ms = 0; mx = XC; my = SY; mvx = 0; mvy = 0; mg = 0;
    end
  endtask

  task automatic drive_frame(input bit rst, input bit kv, input int kx, input int ky);
    exp_t e;
    @(negedge frame_clk);
    Reset = rst; kick_valid = kv; kick_vx = kx[7:0]; kick_vy = ky[7:0];
    if (rst) model_reset();
    else     model_step(kv, kx, ky);
    e.x = mx; e.y = my; e.vx = mvx; e.vy = mvy; e.gl = m_gl; e.gr = m_gr;
    e.ip = (ms == 0) ? 1 : 0;
    sb.push_back(e);
    @(posedge frame_clk);
    #2;
    if (goal_left)  gl_cnt++;
    if (goal_right) gr_cnt++;
    if (!in_play)   ip_low++;
  endtask

  // Scoreboard: compare each registered result against the queued expectation
  always @(posedge frame_clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_x",  int'(BallX), e.x);
      check("sb_y",  int'(BallY), e.y);
      check("sb_vx", int'($signed(BallVX)), e.vx);
      check("sb_vy", int'($signed(BallVY)), e.vy);
      check("sb_gl", int'(goal_left), e.gl);
      check("sb_gr", int'(goal_right), e.gr);
      check("sb_ip", int'(in_play), e.ip);
    end
  end

  initial begin
    drive_frame(1, 0, 0, 0);
    check("rst_x",  int'(BallX), 320);
    check("rst_y",  int'(BallY), 100);
    check("rst_vy", int'($signed(BallVY)), 0);
    check("rst_ip", int'(in_play), 1);
    check("rst_s",  int'(BallS), 12);

    repeat (4) drive_frame(0, 0, 0, 0);
    check("fall_y",  int'(BallY), 104);
    check("fall_vy", int'($signed(BallVY)), 2);
    check("fall_x",  int'(BallX), 320);

    drive_frame(1, 0, 0, 0);
    drive_frame(0, 1, 0, 100);
    check("clamp_vy", int'($signed(BallVY)), 15);
    check("clamp_y",  int'(BallY), 115);
    repeat (31) drive_frame(0, 1, 0, 10);
    check("prefloor_y", int'(BallY), 425);
    drive_frame(0, 1, 0, 10);
    check("floor_y",  int'(BallY), 428);
    check("floor_vy", int'($signed(BallVY)), -5);

    drive_frame(1, 0, 0, 0);
    gl_cnt = 0; gr_cnt = 0;
    repeat (40) drive_frame(0, 1, -8, 0);
    check("wall_x",   int'(BallX), 12);
    check("wall_vx",  int'($signed(BallVX)), 8);
    check("wall_y",   int'(BallY), 100);
    check("wall_nog", gl_cnt + gr_cnt, 0);

    drive_frame(1, 0, 0, 0);
    repeat (33) drive_frame(0, 1, 0, 10);
    check("gl_floor_y", int'(BallY), 428);
    gl_cnt = 0; ip_low = 0;
    repeat (100) drive_frame(0, 1, -8, 0);
    check("gl_pulses", gl_cnt, 1);
    check("gl_iplow",  ip_low, 61);
    check("gl_resp_x", int'(BallX), 320);
    check("gl_resp_y", int'(BallY), 100);
    check("gl_resp_v", int'(BallVX) + int'(BallVY), 0);
    check("gl_resp_ip", int'(in_play), 1);

    drive_frame(1, 0, 0, 0);
    repeat (33) drive_frame(0, 1, 0, 10);
    gr_cnt = 0;
    repeat (39) drive_frame(0, 1, 8, 0);
    check("gr_pulse", gr_cnt, 1);
    check("gr_ip",    int'(in_play), 0);
    repeat (10) drive_frame(0, 1, 8, 0);
    drive_frame(1, 0, 0, 0);
    check("hrst_x",  int'(BallX), 320);
    check("hrst_y",  int'(BallY), 100);
    check("hrst_ip", int'(in_play), 1);
    check("hrst_g",  int'(goal_left) + int'(goal_right), 0);

    drive_frame(1, 0, 0, 0);
    drive_frame(0, 1, 5, 0);
    repeat (150) drive_frame(0, 0, 0, 0);

    drive_frame(1, 0, 0, 0);
    for (int i = 0; i < 250; i++) begin
      int r, kx, ky;
      r  = int'($urandom_range(0, 99));
      kx = int'($urandom_range(0, 40)) - 20;
      ky = int'($urandom_range(0, 40)) - 20;
      if (r < 5) begin kx = -100; ky = 100; end
      drive_frame(0, (r < 25) ? 1'b1 : 1'b0, kx, ky);
    end

    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
